// File: rtl/attn_pkg.sv
// Shared attention-engine types and defaults used by the score transmit stage.
package attn_pkg;

   localparam int unsigned SCORE_W        = 8;
   localparam int unsigned VEC_LEN_DEF    = 4;
   localparam int unsigned FIFO_DEPTH_DEF = 4;

   typedef enum logic [0:0] {
      STREAM = 1'b0,
      WRAP   = 1'b1
   } tx_frame_state_t;

   // Index width that stays at least one bit for degenerate sizes.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/score_fifo.sv
// Score storage FIFO: memory, wrapping pointers and occupancy count.
// No bypass: a word written into an empty FIFO becomes visible next cycle.
module score_fifo
   import attn_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
   parameter int unsigned WIDTH = SCORE_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             wr_data,
   output logic [WIDTH-1:0]             rd_data,
   output logic [$clog2(DEPTH):0]       count
);

   localparam int unsigned PTR_W = idx_w(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/score_tx.sv
// Master-side score transmit stage: FIFO-decoupled handshake, stall overflow
// detection and optional vector framing (enabled by SCORE_TX_LAST_EN).
module score_tx
   import attn_pkg::*;
#(
   parameter int unsigned DEPTH   = FIFO_DEPTH_DEF,
   parameter int unsigned WIDTH   = SCORE_W,
   parameter int unsigned VEC_LEN = VEC_LEN_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_vld,
   output logic             in_rdy,
   output logic [WIDTH-1:0] out_data,
   output logic             out_vld,
   input  logic             out_rdy,
`ifdef SCORE_TX_LAST_EN
   output logic             out_last,
`endif
   output logic             ovf_err
);

   localparam int unsigned CNT_W     = idx_w(DEPTH) + 1;
   localparam int unsigned STALL_MAX = DEPTH + 1;
   localparam int unsigned STALL_W   = $clog2(STALL_MAX + 1);

   logic [CNT_W-1:0]   count;
   logic [WIDTH-1:0]   head;
   logic               push;
   logic               pop;
   logic [STALL_W-1:0] stall_cnt;
   logic [STALL_W-1:0] stall_next;

   score_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data (in_data),
      .rd_data (head),
      .count   (count)
   );

   // Handshake decode from registered occupancy only.
   assign in_rdy   = (count != CNT_W'(DEPTH));
   assign out_vld  = (count != '0);
   assign out_data = out_vld ? head : '0;
   assign push     = in_vld & in_rdy;
   assign pop      = out_vld & out_rdy;

   always_comb begin
      stall_next = stall_cnt;
      if (push) begin
         stall_next = '0;
      end else if (in_vld && !in_rdy && (stall_cnt != STALL_W'(STALL_MAX))) begin
         stall_next = stall_cnt + STALL_W'(1);
      end
   end

   // Overflow flag is sticky until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         ovf_err   <= 1'b0;
      end else begin
         stall_cnt <= stall_next;
         if (stall_next == STALL_W'(STALL_MAX)) begin
            ovf_err <= 1'b1;
         end
      end
   end

`ifdef SCORE_TX_LAST_EN
   localparam int unsigned BEAT_W = idx_w(VEC_LEN);

   tx_frame_state_t  state;
   tx_frame_state_t  state_next;
   tx_frame_state_t  frame;
   logic [BEAT_W-1:0] beat_cnt;
   logic [BEAT_W-1:0] beat_next;
   logic              beat_last;

   assign beat_last = (beat_cnt == BEAT_W'(VEC_LEN - 1));
   assign out_last  = beat_last & out_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= STREAM;
         beat_cnt <= '0;
      end else begin
         state    <= state_next;
         beat_cnt <= beat_next;
      end
   end

   // WRAP is resolved within the same cycle, so the register settles on STREAM.
   always_comb begin
      frame      = state;
      beat_next  = beat_cnt;
      state_next = state;
      case (frame)
         STREAM: begin
            if (pop) begin
               if (beat_last) begin
                  frame = WRAP;
               end else begin
                  beat_next = beat_cnt + BEAT_W'(1);
               end
            end
         end
         default: ;
      endcase
      if (frame == WRAP) begin
         beat_next = '0;
         frame     = STREAM;
      end
      state_next = frame;
   end
`endif

endmodule

// File: doc/score_tx.md
# score_tx

Master-side output stage of the attention engine: accepts 8-bit scores from the exp stage over a producer valid/ready handshake and transmits them off-chip over the master vld/rdy pair. The producer-side handshake is on `in_vld`/`in_rdy`; the off-chip master handshake is `uio_out[2]` as valid and `uio_in[3]` as ready. A small FIFO decouples the two sides. A vector beat counter frames every `VEC_LEN` scores.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `WIDTH`, 8: score width in bits (Q1.6 exp output).
- `VEC_LEN`, 4: scores per vector frame; at least 1.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  WIDTH  score from the exp stage.
- `in_vld`  in  1  producer valid.
- `in_rdy`  out  1  space available; reset 1.
- `out_data`  out  WIDTH  FIFO head, driven to `uo_out`; reset 0.
- `out_vld`  out  1  master valid, driven to `uio_out[2]`; reset 0.
- `out_rdy`  in  1  consumer ready, from `uio_in[3]`.
- `out_last`  out  1  final beat of a vector; reset 0. Present only with `SCORE_TX_LAST_EN`.
- `ovf_err`  out  1  sticky: `in_vld` was held while the FIFO was full for more than `DEPTH` cycles; reset 0.

## Operation
- Push occurs when `in_vld & in_rdy` on a clock edge.
- Pop occurs when `out_vld & out_rdy` on a clock edge.
- `in_rdy` = (count != DEPTH). It is a pure function of registered count, with no combinational path from `out_rdy`.
- `out_vld` = (count != 0). `out_data` = `mem[rd_ptr]`.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Count update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged, and both pointers advance.
  - Full with pop: no push is accepted that cycle, because `in_rdy` = 0.
  - Empty with push: the word is not visible until the next cycle. There is no bypass.
- While `out_vld` = 1 and `out_rdy` = 0, `out_data` and `out_last` hold stable.
- Stall counter, saturating at DEPTH+1:
  - Increments each cycle with `in_vld & !in_rdy`.
  - Clears on any push.
  - Reaching DEPTH+1 sets `ovf_err`. Only `rst` clears `ovf_err`.
- Framing state machine, tracking pops:
  - STREAM: `beat_cnt` counts pops from 0 to VEC_LEN−1. The head is tagged last when `beat_cnt` = VEC_LEN−1. A pop at VEC_LEN−1 moves to WRAP.
  - WRAP: one state for `beat_cnt` reset to 0. Returns to STREAM in the same cycle as the transition, i.e. a combinational wrap. Stall during WRAP is impossible.
  - Net effect: `beat_cnt` wraps to 0 on the last pop.
- Reset mid-operation: FIFO contents are discarded, pointers, count and `beat_cnt` go to 0, and all outputs return to reset values on the cycle after `rst` is sampled high. `mem` itself is not reset.

## Timing
- Latency: a push at edge N gives `out_vld` = 1 with that data after edge N (visible in cycle N+1).
- Throughput: one beat per cycle sustained when `out_rdy` = 1. This holds with DEPTH ≥ 2.
- All outputs are registered or decoded from registered state only. There is no input-to-output combinational path.

## Configuration
- `SCORE_TX_LAST_EN` defined:
  - The `out_last` port and `beat_cnt` logic are present.
  - `out_last` = (`beat_cnt` == VEC_LEN−1) & `out_vld`.
- Undefined:
  - The port and counter are removed.
  - Integration ties `uio_out[4]` to 0.
  - All other behaviour is identical.

## Structure
- Shared package `attn_pkg`:
  - `SCORE_W` = 8.
  - `VEC_LEN_DEF` = 4.
  - `FIFO_DEPTH_DEF` = 4.
  - Framing state enum `tx_frame_state_t` {STREAM, WRAP}.
- One sub-module, `score_fifo`: storage, pointers and count.
- `score_tx` owns the handshake decode, stall/overflow detection and framing.

## Test plan
- Reset: assert `rst` for 2 cycles → `in_rdy`=1, `out_vld`=0, `out_data`=0, `ovf_err`=0, `out_last`=0.
- Single beat: push 0x3A with `out_rdy`=0 → `out_vld`=1 and `out_data`=0x3A from the next cycle, held until `out_rdy`=1; pop, then `out_vld`=0.
- Fill/backpressure: `out_rdy`=0, push 0x01..0x04 → `in_rdy`=0 after the 4th push. Hold `in_vld` with 0x05 for 5 cycles → `ovf_err`=1. Release `out_rdy` → pops 0x01..0x04 in order, then 0x05 is accepted.
- Streaming: `in_vld`=`out_rdy`=1 for 16 cycles with incrementing data → one pop per cycle after the first, count stays at 1, no data loss or reorder.
- Framing (`SCORE_TX_LAST_EN`): stream 8 beats → `out_last`=1 exactly on beats 4 and 8. A stall on beat 4 holds `out_last` high until popped.
- Reset mid-stream: 3 entries queued, assert `rst` → next cycle `out_vld`=0, `in_rdy`=1, `beat_cnt`=0. The next push emerges first.
